// File: rtl/counter_monitor_pkg.sv
// Shared types and constants for the counter_monitor block.
// The FSM state encoding here is also what the debug port `state` reports.
package counter_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_e;

    localparam int WRAP_CNT_W = 8;

endpackage

// File: rtl/counter_monitor_sat_counter.sv
// Saturating up-counter: counts `inc` pulses and holds at all-ones.
// `clr` zeroes it and wins over a simultaneous `inc`.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/counter_monitor.sv
// Watches a free-running counter for a constant-step sequence, flags violations
// (sticky err) and counts legal wraps to zero. Define COUNTER_MONITOR_ASSERT_EN for embedded assertions.
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_value,
    output logic                  in_ready,
    input  logic                  clear,
    output logic                  wrap_pulse,
    output logic                  err,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic [1:0]            state
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_e           state_q;
    logic [WIDTH-1:0] prev_q;
    logic             err_q;
    logic             wrap_pulse_q;

    logic [WIDTH-1:0] expected_d;
    logic             accept;
    logic             legal_d;
    logic             wrap_event;

    // Handshake: a sample transfers on the rising edge where in_valid && in_ready.
    // in_ready drops while in ERROR and whenever clear is asserted.
    assign in_ready   = !clear && (state_q != ERROR);
    assign accept     = in_valid && in_ready;
    assign expected_d = prev_q + STEP_W;
    assign legal_d    = (in_value == expected_d);
    assign wrap_event = accept && (state_q == TRACK) && legal_d
                        && (in_value == '0) && (prev_q != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            err_q        <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else if (clear) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            err_q        <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            wrap_pulse_q <= wrap_event;
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        prev_q  <= in_value;
                        state_q <= TRACK;
                    end
                    TRACK: begin
                        if (legal_d) begin
                            prev_q <= in_value;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    sat_counter #(
        .W(WRAP_CNT_W)
    ) u_wrap_cnt (
        .clk (clk),
        .rstn(rstn),
        .inc (wrap_event),
        .clr (clear),
        .cnt (wrap_count)
    );

    assign state      = state_q;
    assign err        = err_q;
    assign wrap_pulse = wrap_pulse_q;

`ifdef COUNTER_MONITOR_ASSERT_EN
    a_no_state3: assert property (@(posedge clk) disable iff (!rstn)
        state_q != 2'd3);
    a_err_sticky: assert property (@(posedge clk) disable iff (!rstn)
        (err_q && !clear) |=> err_q);
    a_wrap_in_track: assert property (@(posedge clk) disable iff (!rstn)
        wrap_pulse_q |-> (state_q == TRACK));
    a_wrap_cnt_mono: assert property (@(posedge clk) disable iff (!rstn)
        !clear |=> (wrap_count >= $past(wrap_count)));
`else
`endif

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor (WIDTH=4, STEP=1): a vector table plus
// hand-written sequences for saturation and asynchronous reset.
module tb_counter_monitor;

    logic       clk;
    logic       rstn;
    logic       in_valid;
    logic [3:0] in_value;
    logic       in_ready;
    logic       clear;
    logic       wrap_pulse;
    logic       err;
    logic [7:0] wrap_count;
    logic [1:0] state;

    int n_cmp;
    int n_fail;

    counter_monitor #(
        .WIDTH(4),
        .STEP (1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_value  (in_value),
        .in_ready  (in_ready),
        .clear     (clear),
        .wrap_pulse(wrap_pulse),
        .err       (err),
        .wrap_count(wrap_count),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       vld;
        logic [3:0] val;
        logic       exp_rdy;
        logic [1:0] exp_state;
        logic       exp_err;
        logic       exp_wp;
        logic [7:0] exp_wc;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic v, input logic [3:0] x);
        @(negedge clk);
        clear    = c;
        in_valid = v;
        in_value = x;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps;
        int exp_wc;
        logic [3:0] val;

        n_cmp    = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_value = '0;

        //           clr vld val   rdy st err wp wc
        vecs[0]  = '{1'b0, 1'b1, 4'd5,  1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'd6,  1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 4'd7,  1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 4'd14, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 4'd15, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 4'd0,  1'b1, 2'd1, 1'b0, 1'b1, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 4'd1,  1'b1, 2'd1, 1'b0, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 1'b0, 4'd3,  1'b1, 2'd1, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 4'd2,  1'b1, 2'd1, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b1, 4'd3,  1'b1, 2'd1, 1'b0, 1'b0, 8'd1};
        vecs[11] = '{1'b0, 1'b1, 4'd3,  1'b1, 2'd2, 1'b1, 1'b0, 8'd1};
        vecs[12] = '{1'b0, 1'b1, 4'd4,  1'b0, 2'd2, 1'b1, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 1'b1, 4'd9,  1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
        vecs[14] = '{1'b0, 1'b1, 4'd9,  1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
        vecs[15] = '{1'b0, 1'b1, 4'd10, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0};
        vecs[16] = '{1'b0, 1'b1, 4'd0,  1'b1, 2'd2, 1'b1, 1'b0, 8'd0};
        vecs[17] = '{1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 1'b0, 1'b0, 8'd0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_err", err, 0);
        check("rst_wp", wrap_pulse, 0);
        check("rst_wc", wrap_count, 0);
        check("rst_ready", in_ready, 1);
        rstn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].clr, vecs[i].vld, vecs[i].val);
            #1;
            check($sformatf("v%0d_ready", i), in_ready, vecs[i].exp_rdy);
            step();
            check($sformatf("v%0d_state", i), state, vecs[i].exp_state);
            check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("v%0d_wp", i), wrap_pulse, vecs[i].exp_wp);
            check($sformatf("v%0d_wc", i), wrap_count, vecs[i].exp_wc);
        end

        // Zero as the first sample in IDLE is not a wrap; then 300 legal wraps.
        wraps = 0;
        for (int k = 0; k <= 300 * 16; k++) begin
            val = 4'(k % 16);
            drive(1'b0, 1'b1, val);
            step();
            if (k > 0 && val == 4'd0) wraps++;
            exp_wc = (wraps > 255) ? 255 : wraps;
            check("sat_wp", wrap_pulse, (k > 0 && val == 4'd0) ? 1 : 0);
            check("sat_wc", wrap_count, exp_wc);
        end
        check("sat_final_wc", wrap_count, 255);
        check("sat_err", err, 0);
        check("sat_state", state, 1);

        // Mid-TRACK async reset for half a cycle, with a sample offered meanwhile.
        @(posedge clk);
        #2;
        rstn     = 1'b0;
        in_valid = 1'b1;
        in_value = 4'd7;
        #1;
        check("arst_state", state, 0);
        check("arst_err", err, 0);
        check("arst_wp", wrap_pulse, 0);
        check("arst_wc", wrap_count, 0);
        @(negedge clk);
        rstn     = 1'b1;
        in_value = 4'd3;
        step();
        check("post_rst_first_state", state, 1);
        check("post_rst_first_err", err, 0);
        drive(1'b0, 1'b1, 4'd4);
        step();
        check("post_rst_second_state", state, 1);
        check("post_rst_second_err", err, 0);
        drive(1'b0, 1'b0, 4'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bit width of the observed counter value.
REQ-002 The block SHALL have parameter STEP, default 1, giving the expected increment between consecutive accepted samples, modulo 2^WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit, the reset: asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_value carries a sample this cycle.
REQ-006 The block SHALL have port in_value, input, WIDTH bits: the observed counter value.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the monitor accepts a sample this cycle.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous return to IDLE.
REQ-009 The block SHALL have port wrap_pulse, output, 1 bit: a one-cycle pulse on a legal wrap to 0.
REQ-010 The block SHALL have port err, output, 1 bit: a sticky sequence-violation flag.
REQ-011 The block SHALL have port wrap_count, output, 8 bits: the saturating count of legal wraps.
REQ-012 The block SHALL have port state, output, 2 bits: the current FSM state encoding.

Function
REQ-013 A sample SHALL be accepted on a rising clk edge when in_valid and in_ready are both 1.
REQ-014 in_ready SHALL be 1 in IDLE and TRACK, and 0 in ERROR and in any cycle where clear=1.
REQ-015 The FSM SHALL have states IDLE=0, TRACK=1 and ERROR=2; encoding 3 SHALL be unreachable.
REQ-016 In IDLE, an accepted sample SHALL be stored as prev and SHALL move the FSM to TRACK; any value is legal.
REQ-017 In TRACK, expected SHALL equal (prev+STEP) truncated to WIDTH bits.
REQ-018 In TRACK, an accepted in_value equal to expected SHALL update prev and keep the FSM in TRACK.
REQ-019 In TRACK, an accepted in_value differing from expected SHALL move the FSM to ERROR, set err, and leave prev unchanged; this includes in_value equal to prev.
REQ-020 An accepted legal sample with in_value==0 and prev!=0 SHALL assert wrap_pulse on the next cycle only.
REQ-021 The same wrap event SHALL increment wrap_count, which holds at 255 once reached.
REQ-022 err, wrap_pulse, wrap_count and state SHALL be registered, with 1-cycle latency from the accepting edge.
REQ-023 A cycle with in_valid=0 SHALL change no state and SHALL drive wrap_pulse to 0.
REQ-024 ERROR SHALL persist until clear or reset; in_valid SHALL be ignored while in ERROR.
REQ-025 clear=1 SHALL, from any state, move the FSM to IDLE and zero err, wrap_count and prev; clear has priority over a simultaneous in_valid.

Reset
REQ-026 rstn=0 SHALL immediately force state=IDLE, prev=0, err=0, wrap_pulse=0 and wrap_count=0, independent of clk.
REQ-027 Reset asserted mid-sequence SHALL discard any sample offered in that cycle; after release the first accepted sample SHALL be treated as in IDLE.

Configuration
REQ-028 When macro COUNTER_MONITOR_ASSERT_EN is defined, the block SHALL embed concurrent assertions, all disabled while rstn=0:
- state never equals 3;
- err is never cleared except by clear or reset;
- wrap_pulse implies state==TRACK;
- wrap_count never decreases except on clear or reset.
REQ-029 When COUNTER_MONITOR_ASSERT_EN is undefined, the block SHALL contain no assertions and SHALL behave identically at its ports.

Structure
REQ-030 A package counter_monitor_pkg SHALL hold the state enum typedef (IDLE, TRACK, ERROR) and constant WRAP_CNT_W=8.
REQ-031 The wrap counter SHALL be a sub-module sat_counter (width WRAP_CNT_W; inc and clr inputs; saturates at all-ones).

Verification (WIDTH=4, STEP=1)
REQ-032 Input 5,6,7 -> err stays 0 and state==TRACK after the first sample.
REQ-033 Input 14,15,0,1 -> wrap_pulse is high exactly one cycle after 0 is accepted, and wrap_count==1.
REQ-034 Input 3,3 -> err=1 and state=ERROR one cycle after the second 3; in_ready=0; further samples are ignored.
REQ-035 In ERROR, assert clear together with in_valid and value 9 -> state=IDLE, err=0, sample not accepted; next value 9 is accepted as the first sample.
REQ-036 Issue 300 legal wraps -> wrap_count saturates at 255.
REQ-037 Drive rstn low for half a cycle mid-TRACK -> all outputs are immediately 0 and state=IDLE.
